memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter that shares the single 128-bit-block main memory between the instruction cache and the data cache. It sits between the two cache controllers' memory-side ports and the main memory. It serialises their block reads and writes with round-robin arbitration. Each requester sees a private memory port with its own busywait.

## Interface
Parameters:
- ADDR_W, 28, block address width (byte address [31:4])
- BLOCK_W, 128, block data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_mem_read  in  1  instruction-cache block read request
- i_mem_address  in  ADDR_W  instruction-cache block address
- i_mem_readinst  out  BLOCK_W  block returned to instruction cache
- i_mem_busywait  out  1  instruction-cache stall
- d_mem_read  in  1  data-cache block read request
- d_mem_write  in  1  data-cache block write-back request
- d_mem_address  in  ADDR_W  data-cache block address
- d_mem_writedata  in  BLOCK_W  data-cache write-back block
- d_mem_readdata  out  BLOCK_W  block returned to data cache
- d_mem_busywait  out  1  data-cache stall
- mem_read  out  1  main-memory read
- mem_write  out  1  main-memory write
- mem_address  out  ADDR_W  main-memory block address
- mem_writedata  out  BLOCK_W  main-memory write data
- mem_readdata  in  BLOCK_W  main-memory read data
- mem_busywait  in  1  main-memory busy

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- Registers: state, grant owner, last_served (I/D), first_cycle flag, latched op/address/writedata, i_rdata and d_rdata holding registers.

**IDLE**
- Sample requests at each posedge. I request = i_mem_read. D request = d_mem_read | d_mem_write.
- Exactly one request pending: grant that requester.
- Both pending: grant the requester that is not last_served.
- On grant, latch the requester's address, op and (for D) writedata, set first_cycle=1, and go to GRANT_x.
- Requester inputs changing during a grant are ignored.
- d_mem_read and d_mem_write both high: the request is treated as a write.

**GRANT_x**
- mem_read/mem_write drive the latched op; mem_address/mem_writedata drive the latched values.
- On the first cycle, mem_busywait is ignored and first_cycle is cleared.
- On a later posedge with mem_busywait=0:
  - capture mem_readdata into the owner's holding register (reads only);
  - update last_served to the owner;
  - go to DONE.

**DONE** (one cycle)
- mem_read=mem_write=0.
- The owner's busywait is 0.
- Next state is IDLE.
- The request must be re-sampled only in IDLE, so a requester that drops its request at the DONE edge is not re-granted.

**Outputs**
- i_mem_busywait = i_mem_read & ~(state==DONE & owner==I).
- d_mem_busywait is the same form using the D request and owner==D.
- i_mem_readinst and d_mem_readdata come straight from the holding registers. Each holds its value until that port's next read completion.
- In IDLE and DONE: mem_address=0, mem_writedata=0, mem_read=mem_write=0.

## Timing
- Reset low: state=IDLE, last_served=I (so the first tie goes to D), holding registers=0, mem_read=mem_write=0, mem_address=0, mem_writedata=0, both busywaits forced 0. All take effect asynchronously.
- Reset asserted mid-transaction aborts it immediately. Memory strobes drop without waiting for mem_busywait.
- Request asserted before posedge k (in IDLE) → GRANT from k, with the memory strobe visible after k.
- Memory completing with mem_busywait low at posedge k+N (N≥1) → DONE from k+N to k+N+1, with the requester's busywait low in that cycle.
- Unloaded latency from request sampled to busywait low is N+1 edges. Minimum gap between back-to-back grants is one IDLE cycle.
- Busywait rises combinationally in the same cycle a request is raised. A request is never missed or completed early.
- The non-owner stays stalled for the entire foreign transaction. Its worst-case wait is one foreign transaction plus its own.

## Test plan
- Single I read: i_mem_read=1, addr 28'h0000010, memory returns 128'hA5…A5 after 5 busy cycles → mem_read high for 6 cycles, i_mem_busywait low for exactly the DONE cycle, i_mem_readinst=128'hA5…A5, d_mem_busywait stays 0.
- Simultaneous first requests (I read 0x10, D write 0x20 with data 128'h1234): D is granted first (mem_write, address 0x20); I is granted after one IDLE cycle; i_mem_busywait stays 1 throughout D's transaction.
- Alternation: both ports hold requests continuously for 4 transactions → grant order D,I,D,I with no starvation; last_served toggles each DONE.
- Latch check: change d_mem_address from 0x20 to 0x30 two cycles into GRANT_D → mem_address stays 0x20 until DONE.
- Reset mid-transaction: pull reset low in the 3rd cycle of GRANT_I → mem_read drops within the same cycle, busywaits 0, state IDLE. After release, a pending I request is re-granted from scratch.
- Read/write conflict: d_mem_read=d_mem_write=1 → memory sees a write only, and d_mem_readdata is unchanged.

Source files
------------

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one block-wide main memory between the I-cache and the D-cache.
// A grant latches the winner's op/address/data, so requester inputs may change mid-transaction.
module memory_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_mem_read,
    input  logic [ADDR_W-1:0]  i_mem_address,
    output logic [BLOCK_W-1:0] i_mem_readinst,
    output logic               i_mem_busywait,
    input  logic               d_mem_read,
    input  logic               d_mem_write,
    input  logic [ADDR_W-1:0]  d_mem_address,
    input  logic [BLOCK_W-1:0] d_mem_writedata,
    output logic [BLOCK_W-1:0] d_mem_readdata,
    output logic               d_mem_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;              // 1 = D-cache owns the memory
    logic                 last_served_q, last_served_d;  // 1 = D-cache was served last
    logic                 first_q, first_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    logic [BLOCK_W-1:0]   i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0]   d_rdata_q, d_rdata_d;

    logic i_req, d_req, grant_d_sel, granted, done_i, done_d;

    assign i_req       = i_mem_read;
    assign d_req       = d_mem_read | d_mem_write;
    assign grant_d_sel = d_req & (~i_req | ~last_served_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_served_q <= 1'b0;
            first_q       <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            first_q       <= first_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        first_d       = first_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    first_d = 1'b1;
                    owner_d = grant_d_sel;
                    if (grant_d_sel) begin
                        // A simultaneous read+write from the D-cache is served as a write.
                        wr_d    = d_mem_write;
                        addr_d  = d_mem_address;
                        wdata_d = d_mem_writedata;
                        state_d = GRANT_D;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = i_mem_address;
                        wdata_d = '0;
                        state_d = GRANT_I;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                // Memory busywait lags the strobe by a cycle, so the first cycle never completes.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!mem_busywait) begin
                    if (!wr_q) begin
                        if (owner_q) d_rdata_d = mem_readdata;
                        else         i_rdata_d = mem_readdata;
                    end
                    last_served_d = owner_q;
                    state_d       = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign granted = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign done_i  = (state_q == DONE) && !owner_q;
    assign done_d  = (state_q == DONE) && owner_q;

    assign mem_read      = granted & ~wr_q;
    assign mem_write     = granted & wr_q;
    assign mem_address   = granted ? addr_q  : '0;
    assign mem_writedata = granted ? wdata_q : '0;

    // Gated by reset so both stalls drop the moment reset is asserted.
    assign i_mem_busywait = reset & i_req & ~done_i;
    assign d_mem_busywait = reset & d_req & ~done_d;

    assign i_mem_readinst = i_rdata_q;
    assign d_mem_readdata = d_rdata_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: latency-randomised memory model, transaction-level reference with scoreboards.
module tb_memory_arbiter;
    localparam int AW = 28;
    localparam int BW = 128;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [BW-1:0] data;
    } d_exp_t;

    logic          clock, reset;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [BW-1:0] i_mem_readinst;
    logic          i_mem_busywait;
    logic          d_mem_read, d_mem_write;
    logic [AW-1:0] d_mem_address;
    logic [BW-1:0] d_mem_writedata, d_mem_readdata;
    logic          d_mem_busywait;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_writedata, mem_readdata;
    logic          mem_busywait;

    memory_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clock(clock), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_readinst(i_mem_readinst), .i_mem_busywait(i_mem_busywait),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
        .d_mem_writedata(d_mem_writedata), .d_mem_readdata(d_mem_readdata),
        .d_mem_busywait(d_mem_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Main-memory model: 64 blocks indexed by address[5:0], busy for lat_cur cycles per access.
    logic [BW-1:0] mem_arr [0:63];
    logic [BW-1:0] ref_mem [0:63];
    int lat_cur = 0, mcnt = 0, force_lat = -1;

    always @(posedge clock) begin
        #1;
        if (mem_read || mem_write) begin
            if (mcnt == 0) lat_cur = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
            mem_busywait = (mcnt < lat_cur);
            if (!mem_busywait) begin
                mem_readdata = mem_arr[mem_address[5:0]];
                if (mem_write) mem_arr[mem_address[5:0]] = mem_writedata;
            end else begin
                mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            mcnt++;
        end else begin
            mcnt         = 0;
            mem_busywait = 1'b1;
            mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // Reference state: current request of each port, expected responses, arbitration history.
    logic [AW-1:0] cur_i_addr = '0, cur_d_addr = '0;
    logic          cur_d_wr = 1'b0;
    logic [BW-1:0] cur_d_data = '0;
    logic [BW-1:0] i_q [$];
    d_exp_t        d_q [$];
    d_exp_t        de;
    logic [BW-1:0] d_last_rd = '0;
    bit            mon_en = 1'b0;
    logic          pi_s = 1'b0, pd_s = 1'b0;
    logic          strobe_now, strobe_prev = 1'b0;
    logic          owner_m = 1'b0, last_d_m = 1'b0, wr_m = 1'b0;
    logic [AW-1:0] addr_m = '0;
    logic [BW-1:0] wd_m = '0;
    int            strobe_len = 0;
    bit            grant_log [$];

    always @(posedge clock) begin
        pi_s <= i_mem_read;
        pd_s <= d_mem_read | d_mem_write;
    end

    // Memory-side monitor: who is granted, what the memory sees, and how long.
    always @(negedge clock) begin
        if (mon_en) begin
            strobe_now = mem_read | mem_write;
            if (strobe_now && !strobe_prev) begin
                chk("grant_has_request", BW'(pi_s | pd_s), BW'(1));
                owner_m = pd_s & (~pi_s | ~last_d_m);
                wr_m    = owner_m & cur_d_wr;
                addr_m  = owner_m ? cur_d_addr : cur_i_addr;
                wd_m    = cur_d_data;
                strobe_len = 0;
                grant_log.push_back(owner_m);
            end
            if (strobe_now) begin
                strobe_len++;
                chk("mem_op", BW'({mem_read, mem_write}), BW'({~wr_m, wr_m}));
                chk("mem_address", BW'(mem_address), BW'(addr_m));
                if (wr_m) chk("mem_writedata", mem_writedata, wd_m);
                if (i_mem_read) chk("i_busy_stall", BW'(i_mem_busywait), BW'(1));
                if (d_mem_read || d_mem_write) chk("d_busy_stall", BW'(d_mem_busywait), BW'(1));
            end else begin
                chk("idle_address", BW'(mem_address), BW'(0));
                chk("idle_wdata", mem_writedata, BW'(0));
                if (strobe_prev) begin
                    chk("strobe_len", BW'(strobe_len), BW'(((lat_cur < 1) ? 1 : lat_cur) + 1));
                    chk("done_busy", BW'(owner_m ? d_mem_busywait : i_mem_busywait), BW'(0));
                    last_d_m = owner_m;
                end
            end
            strobe_prev = strobe_now;
        end
    end

    // Port-side monitor: pops the scoreboard whenever a port's stall drops.
    always @(negedge clock) begin
        if (mon_en) begin
            if (i_mem_read && !i_mem_busywait) begin
                chk("i_done_pending", BW'(i_q.size() > 0), BW'(1));
                if (i_q.size() > 0) chk("i_readinst", i_mem_readinst, i_q.pop_front());
            end
            if (!i_mem_read) chk("i_busy_idle", BW'(i_mem_busywait), BW'(0));
            if ((d_mem_read || d_mem_write) && !d_mem_busywait) begin
                chk("d_done_pending", BW'(d_q.size() > 0), BW'(1));
                if (d_q.size() > 0) begin
                    de = d_q.pop_front();
                    if (de.wr) begin
                        chk("mem_written", mem_arr[de.a[5:0]], de.data);
                        chk("d_readdata_hold", d_mem_readdata, d_last_rd);
                    end else begin
                        chk("d_readdata", d_mem_readdata, de.data);
                        d_last_rd = de.data;
                    end
                end
            end
            if (!(d_mem_read || d_mem_write)) chk("d_busy_idle", BW'(d_mem_busywait), BW'(0));
        end
    end

    task automatic wait_done(input logic is_d);
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (!(is_d ? d_mem_busywait : i_mem_busywait)) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL %s_timeout: busywait still 1 after 300 cycles, required 0", is_d ? "d" : "i");
    endtask

    task automatic i_txn(input logic [AW-1:0] a, input int gap);
        @(posedge clock); #1;
        i_mem_address = a;
        i_mem_read    = 1'b1;
        cur_i_addr    = a;
        i_q.push_back(ref_mem[a[5:0]]);
        wait_done(1'b0);
        if (gap > 0) begin
            @(posedge clock); #1;
            i_mem_read = 1'b0;
            repeat (gap - 1) @(posedge clock);
        end
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] data, input int gap);
        d_exp_t e;
        @(posedge clock); #1;
        d_mem_read      = rd;
        d_mem_write     = wr;
        d_mem_address   = a;
        d_mem_writedata = data;
        cur_d_addr      = a;
        cur_d_wr        = wr;
        cur_d_data      = data;
        if (wr) ref_mem[a[5:0]] = data;
        e.wr   = wr;
        e.a    = a;
        e.data = ref_mem[a[5:0]];
        d_q.push_back(e);
        wait_done(1'b1);
        if (gap > 0) begin
            @(posedge clock); #1;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            repeat (gap - 1) @(posedge clock);
        end
    endtask

    // I-cache addresses live in blocks 0..31, D-cache in 32..63, upper address bits random.
    function automatic logic [AW-1:0] rand_addr(input logic region);
        logic [31:0] r;
        r = $urandom();
        return {r[26:5], region, r[4:0]};
    endfunction

    task automatic check_log(input string nm, input int n, input logic [3:0] exp);
        logic [3:0] v;
        v = '0;
        chk({nm, "_count"}, BW'(grant_log.size()), BW'(n));
        for (int k = 0; k < grant_log.size() && k < 4; k++) v = {v[2:0], grant_log[k]};
        chk(nm, BW'(v), BW'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] wdat;
        logic [31:0]   r;
        for (int k = 0; k < 64; k++) mem_arr[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_arr[16] = {16{8'hA5}};
        for (int k = 0; k < 64; k++) ref_mem[k] = mem_arr[k];
        mem_busywait    = 1'b1;
        mem_readdata    = '0;
        i_mem_address   = '0;
        d_mem_address   = '0;
        d_mem_writedata = '0;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        i_mem_read      = 1'b1;
        reset           = 1'b1;
        #1 reset = 1'b0;
        d_mem_read = 1'b1;
        #2;
        chk("rst_i_busy", BW'(i_mem_busywait), BW'(0));
        chk("rst_d_busy", BW'(d_mem_busywait), BW'(0));
        chk("rst_strobes", BW'({mem_read, mem_write}), BW'(0));
        chk("rst_address", BW'(mem_address), BW'(0));
        chk("rst_wdata", mem_writedata, BW'(0));
        chk("rst_readinst", i_mem_readinst, BW'(0));
        chk("rst_readdata", d_mem_readdata, BW'(0));
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // Single I read, five busy cycles
        force_lat = 5;
        i_txn(28'h0000010, 1);

        // Simultaneous requests: D wins the tie first
        force_lat = 3;
        grant_log.delete();
        fork
            i_txn(28'h0000010, 1);
            d_txn(1'b0, 1'b1, 28'h0000020, 128'h1234, 1);
        join
        check_log("tie_order", 2, 4'b0010);

        // Continuous requests from both ports alternate
        force_lat = -1;
        grant_log.delete();
        fork
            begin i_txn(rand_addr(1'b0), 0); i_txn(rand_addr(1'b0), 1); end
            begin d_txn(1'b1, 1'b0, rand_addr(1'b1), '0, 0); d_txn(1'b0, 1'b1, rand_addr(1'b1), 128'hBEEF, 1); end
        join
        check_log("alt_order", 4, 4'b1010);

        // Address/data change two cycles into a D grant is ignored
        force_lat = 4;
        wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
        fork
            d_txn(1'b0, 1'b1, 28'h0000020, wdat, 1);
            begin
                for (int n = 0; n < 20; n++) begin
                    @(posedge clock); #1;
                    if (mem_write) break;
                end
                repeat (2) @(posedge clock);
                #1;
                d_mem_address   = 28'h0000030;
                d_mem_writedata = ~wdat;
            end
        join
        d_txn(1'b1, 1'b0, 28'h0000020, '0, 1);

        // Read and write together behave as a write
        d_txn(1'b1, 1'b1, 28'h0000025, {$urandom(), $urandom(), $urandom(), $urandom()}, 1);

        // Reset in the third cycle of an I grant
        force_lat = 5;
        @(posedge clock); #1;
        i_mem_address = 28'h0000011;
        i_mem_read    = 1'b1;
        cur_i_addr    = 28'h0000011;
        i_q.push_back(ref_mem[17]);
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (mem_read) break;
        end
        repeat (2) @(posedge clock);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("abort_strobes", BW'({mem_read, mem_write}), BW'(0));
        chk("abort_i_busy", BW'(i_mem_busywait), BW'(0));
        chk("abort_address", BW'(mem_address), BW'(0));
        chk("abort_readinst", i_mem_readinst, BW'(0));
        repeat (2) @(posedge clock);
        #1;
        i_q.delete();
        d_q.delete();
        i_q.push_back(ref_mem[17]);
        d_last_rd   = '0;
        last_d_m    = 1'b0;
        strobe_prev = 1'b0;
        mon_en      = 1'b1;
        reset       = 1'b1;
        wait_done(1'b0);
        @(posedge clock); #1;
        i_mem_read = 1'b0;

        // Randomised traffic from both ports
        force_lat = -1;
        fork
            for (int k = 0; k < 40; k++)
                i_txn(rand_addr(1'b0), (k == 39) ? 1 : int'($urandom_range(0, 3)));
            for (int k = 0; k < 40; k++) begin
                r = $urandom();
                d_txn(r[1] | ~r[0], r[0], rand_addr(1'b1),
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      (k == 39) ? 1 : int'($urandom_range(0, 3)));
            end
        join
        repeat (5) @(posedge clock);
        chk("i_queue_drained", BW'(i_q.size()), BW'(0));
        chk("d_queue_drained", BW'(d_q.size()), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
